// File: rtl/vga_fb_arbiter_if.sv
// Signal bundle between the frame-buffer arbiter and its surroundings:
// the vga_sync strobes, the pixel output, the writer port and the SRAM port.
interface vga_fb_arbiter_if #(
    parameter int DW = 12,
    parameter int AW = 19
);
    logic          vga_vsync;
    logic          vga_video_on;
    logic [DW-1:0] pixel_data;
    logic          underflow;

    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic          sram_ce;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    // The arbiter
    modport slave (
        input  vga_vsync, vga_video_on, wr_valid, wr_addr, wr_data, sram_rdata,
        output pixel_data, underflow, wr_ready, sram_ce, sram_we, sram_addr, sram_wdata
    );

    // The environment: timing generator, writer and SRAM
    modport master (
        output vga_vsync, vga_video_on, wr_valid, wr_addr, wr_data, sram_rdata,
        input  pixel_data, underflow, wr_ready, sram_ce, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port SRAM frame-buffer arbiter: raster-order display prefetch into a
// small FIFO, with an external writer that can preempt once it has starved.
module vga_fb_arbiter #(
    parameter int HVA        = 640,
    parameter int VVA        = 480,
    parameter int DW         = 12,
    parameter int AW         = 19,
    parameter int FIFO_DEPTH = 8,
    parameter int LOW_WM     = 4,
    parameter int MAX_WAIT   = 4,
    parameter bit VSYNC_POL  = 1'b0
) (
    input  logic            clk_vga,
    input  logic            rst_n,
    vga_fb_arbiter_if.slave bus
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [AW:0]   NPIX    = (AW+1)'(HVA * VVA);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LOW_L   = LW'(LOW_WM);
    localparam logic [WW-1:0] WAIT_L  = WW'(MAX_WAIT);

    typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    state_t          state_q, state_d;
    logic            vsync_q;
    logic [AW:0]     rd_addr_q, rd_addr_d;
    logic            inflight_q, inflight_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [LW-1:0]   level_q, level_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]   pixel_q, pixel_d;
    logic            underflow_q, underflow_d;
    logic [DW-1:0]   mem_q [FIFO_DEPTH];

    logic frame_start;
    logic fetch_req;
    logic wr_grant;
    logic rd_grant;
    logic push;
    logic empty;
    logic pop_ok;

    // rst_n gates the grants so the SRAM port is idle while reset is held
    always_comb begin
        frame_start = (bus.vga_vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);
        fetch_req   = rst_n && (state_q == ST_RUN) && (rd_addr_q < NPIX) &&
                      ((level_q + LW'(inflight_q)) < DEPTH_L);
        wr_grant    = rst_n && bus.wr_valid &&
                      (!fetch_req || ((wait_q == WAIT_L) && (level_q >= LOW_L)));
        rd_grant    = fetch_req && !wr_grant;
        push        = inflight_q && (state_q != ST_FLUSH);
        empty       = (level_q == '0);
        pop_ok      = bus.vga_video_on && !empty;
    end

    always_comb begin
        bus.wr_ready   = wr_grant;
        bus.sram_ce    = 1'b0;
        bus.sram_we    = 1'b0;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        if (wr_grant) begin
            bus.sram_ce    = 1'b1;
            bus.sram_we    = 1'b1;
            bus.sram_addr  = bus.wr_addr;
            bus.sram_wdata = bus.wr_data;
        end else if (rd_grant) begin
            bus.sram_ce    = 1'b1;
            bus.sram_addr  = rd_addr_q[AW-1:0];
        end
    end

    always_comb begin
        state_d     = ST_RUN;
        rd_addr_d   = rd_addr_q;
        inflight_d  = rd_grant;
        level_d     = level_q + LW'(push) - LW'(pop_ok);
        wr_ptr_d    = push   ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
        pixel_d     = pop_ok ? mem_q[rd_ptr_q] : '0;
        underflow_d = underflow_q | (bus.vga_video_on && empty);
        wait_d      = wait_q;

        if (!bus.wr_valid || wr_grant) begin
            wait_d = '0;
        end else if (wait_q != WAIT_L) begin
            wait_d = wait_q + WW'(1);
        end

        if (state_q == ST_FLUSH) begin
            // The word returning now belongs to the previous frame and is dropped
            rd_addr_d  = '0;
            inflight_d = 1'b0;
            level_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (frame_start) begin
                state_d = ST_FLUSH;
            end
            if (rd_grant) begin
                rd_addr_d = rd_addr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            vsync_q     <= ~VSYNC_POL;
            rd_addr_q   <= '0;
            inflight_q  <= 1'b0;
            wait_q      <= '0;
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pixel_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= bus.vga_vsync;
            rd_addr_q   <= rd_addr_d;
            inflight_q  <= inflight_d;
            wait_q      <= wait_d;
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pixel_q     <= pixel_d;
            underflow_q <= underflow_d;
        end
    end

    // FIFO storage carries no reset; the level/pointers define what is valid
    always_ff @(posedge clk_vga) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.sram_rdata;
        end
    end

    assign bus.pixel_data = pixel_q;
    assign bus.underflow  = underflow_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter on a reduced 16x8 frame with a behavioural
// single-port SRAM preloaded with SRAM[i] = i.
module tb_vga_fb_arbiter;

    localparam int DW   = 12;
    localparam int AW   = 19;
    localparam int HVA  = 16;
    localparam int VVA  = 8;
    localparam int NPIX = HVA * VVA;

    logic clk_vga = 1'b0;
    logic rst_n   = 1'b1;
    bit   loaded  = 1'b0;
    int   total   = 0;
    int   bad     = 0;
    int   grants  = 0;
    logic [DW-1:0] sram [0:255];
    logic [DW-1:0] exp_pix;

    vga_fb_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    vga_fb_arbiter #(
        .HVA(HVA), .VVA(VVA), .DW(DW), .AW(AW),
        .FIFO_DEPTH(8), .LOW_WM(4), .MAX_WAIT(4), .VSYNC_POL(1'b0)
    ) dut (
        .clk_vga (clk_vga),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_vga = ~clk_vga;

    // SRAM model: read data valid one cycle after the read is issued
    always @(posedge clk_vga) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) sram[i] = DW'(i);
            loaded = 1'b1;
        end else if (bus.sram_ce) begin
            if (bus.sram_we) sram[bus.sram_addr[7:0]] = bus.sram_wdata;
            else             bus.sram_rdata <= sram[bus.sram_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_vga);
        #1;
    endtask

    initial begin
        bus.vga_vsync    = 1'b1;
        bus.vga_video_on = 1'b0;
        bus.wr_valid     = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_data      = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ce",    32'(bus.sram_ce),    0);
        chk("rst_we",    32'(bus.sram_we),    0);
        chk("rst_addr",  32'(bus.sram_addr),  0);
        chk("rst_wdata", 32'(bus.sram_wdata), 0);
        chk("rst_ready", 32'(bus.wr_ready),   0);
        chk("rst_pix",   32'(bus.pixel_data), 0);
        chk("rst_uf",    32'(bus.underflow),  0);
        $display("reset state checked");

        // Post-reset prefetch: addresses 0..7, then stop with the FIFO full
        @(posedge clk_vga);
        @(posedge clk_vga);
        #1 rst_n = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("fill_ce%0d", k),   32'(bus.sram_ce),   1);
            chk($sformatf("fill_we%0d", k),   32'(bus.sram_we),   0);
            chk($sformatf("fill_addr%0d", k), 32'(bus.sram_addr), k);
            $display("fetch addr=%0d", bus.sram_addr);
            step();
        end
        chk("full_ce_a", 32'(bus.sram_ce), 0);
        step();
        chk("full_ce_b", 32'(bus.sram_ce), 0);
        chk("full_uf",   32'(bus.underflow), 0);
        chk("full_pix",  32'(bus.pixel_data), 0);

        // Blanking write of 0xABC to pixel 100: granted at once, fetch is idle
        bus.wr_valid = 1'b1;
        bus.wr_addr  = AW'(100);
        bus.wr_data  = 12'hABC;
        #1;
        chk("blank_ready", 32'(bus.wr_ready),   1);
        chk("blank_ce",    32'(bus.sram_ce),    1);
        chk("blank_we",    32'(bus.sram_we),    1);
        chk("blank_addr",  32'(bus.sram_addr),  100);
        chk("blank_wdata", 32'(bus.sram_wdata), 32'h0ABC);
        $display("write addr=100 data=abc");
        step();
        bus.wr_valid = 1'b0;
        #1;
        chk("blank_idle", 32'(bus.sram_ce), 0);

        // Frame start: one FLUSH cycle with no access, then fetch from addr 0
        bus.vga_vsync = 1'b0;
        #1;
        chk("vs1_ce", 32'(bus.sram_ce), 0);
        step();
        bus.vga_vsync = 1'b1;
        #1;
        chk("flush1_ce", 32'(bus.sram_ce), 0);
        step();

        // Starving writer during refill: waits 4 cycles, granted once level hits 4
        bus.wr_valid = 1'b1;
        bus.wr_addr  = AW'(200);
        bus.wr_data  = 12'h555;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("starve_ready%0d", k), 32'(bus.wr_ready),  0);
            chk($sformatf("starve_ce%0d", k),    32'(bus.sram_ce),   1);
            chk($sformatf("starve_we%0d", k),    32'(bus.sram_we),   0);
            chk($sformatf("starve_addr%0d", k),  32'(bus.sram_addr), k);
            step();
        end
        chk("guard_ready", 32'(bus.wr_ready),   1);
        chk("guard_we",    32'(bus.sram_we),    1);
        chk("guard_addr",  32'(bus.sram_addr),  200);
        chk("guard_wdata", 32'(bus.sram_wdata), 32'h555);
        $display("write addr=200 data=555 after starvation");
        step();

        // vsync edge with level 5 and the addr-5 read in flight
        bus.wr_valid  = 1'b0;
        bus.vga_vsync = 1'b0;
        #1;
        chk("vs2_ce",   32'(bus.sram_ce),   1);
        chk("vs2_we",   32'(bus.sram_we),   0);
        chk("vs2_addr", 32'(bus.sram_addr), 5);
        step();
        bus.vga_vsync = 1'b1;
        #1;
        chk("flush2_ce", 32'(bus.sram_ce), 0);
        step();
        chk("restart_ce",   32'(bus.sram_ce),   1);
        chk("restart_we",   32'(bus.sram_we),   0);
        chk("restart_addr", 32'(bus.sram_addr), 0);

        // Full frame with the writer held valid outside the visible range
        repeat (12) step();
        bus.vga_video_on = 1'b1;
        bus.wr_valid     = 1'b1;
        bus.wr_addr      = AW'(200);
        bus.wr_data      = 12'h777;
        for (int i = 0; i < NPIX; i++) begin
            step();
            exp_pix = (i == 100) ? 12'hABC : DW'(i);
            chk($sformatf("pix%0d", i), 32'(bus.pixel_data), 32'(exp_pix));
            chk($sformatf("pix_uf%0d", i), 32'(bus.underflow), 0);
            if (bus.wr_ready) grants++;
            if (i == NPIX - 1) begin
                bus.vga_video_on = 1'b0;
                bus.wr_valid     = 1'b0;
            end
        end
        $display("frame done, writer grants=%0d", grants);
        step();
        chk("pix_off",    32'(bus.pixel_data), 0);
        chk("eof_idle",   32'(bus.sram_ce),    0);
        chk("wr_granted", 32'(grants > 0),     1);

        // Mid-line asynchronous reset
        bus.vga_vsync = 1'b0;
        step();
        bus.vga_vsync = 1'b1;
        step();
        repeat (12) step();
        bus.vga_video_on = 1'b1;
        repeat (10) step();
        chk("pre_rst_pix", 32'(bus.pixel_data), 9);
        bus.wr_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_pix",   32'(bus.pixel_data), 0);
        chk("async_uf",    32'(bus.underflow),  0);
        chk("async_ce",    32'(bus.sram_ce),    0);
        chk("async_we",    32'(bus.sram_we),    0);
        chk("async_addr",  32'(bus.sram_addr),  0);
        chk("async_wdata", 32'(bus.sram_wdata), 0);
        chk("async_ready", 32'(bus.wr_ready),   0);
        $display("async reset mid-line checked");
        bus.wr_valid = 1'b0;
        step();
        step();

        // video_on already high at reset release: empty pop sets sticky underflow
        rst_n = 1'b1;
        #1;
        chk("rel_ce",   32'(bus.sram_ce),   1);
        chk("rel_addr", 32'(bus.sram_addr), 0);
        step();
        chk("uf_pix", 32'(bus.pixel_data), 0);
        chk("uf_set", 32'(bus.underflow),  1);
        bus.vga_video_on = 1'b0;
        repeat (5) step();
        chk("uf_sticky", 32'(bus.underflow), 1);
        rst_n = 1'b0;
        #1;
        chk("uf_clr", 32'(bus.underflow), 0);
        $display("underflow set and cleared by reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
